// File: rtl/proj_pkg.sv
// Shared constants and types for the k-mer builder / hasher / sorter pipeline.
package proj_pkg;

    localparam int KMER_LEN                = 16;
    localparam int BASE_LEN                = 2;
    localparam int HASHER_SORTER_SIGNATURE = 32;
    localparam int KMER_BITS               = KMER_LEN * BASE_LEN;
    localparam int KMER_IDX_BITS           = 16;

    typedef logic [BASE_LEN-1:0] base_t;

    localparam base_t BASE_A = 2'd0;
    localparam base_t BASE_C = 2'd1;
    localparam base_t BASE_G = 2'd2;
    localparam base_t BASE_T = 2'd3;

    typedef enum logic {
        ST_FILL,
        ST_STREAM
    } kmer_state_e;

endpackage

// File: rtl/proj_kmer_out_reg.sv
// Single-entry valid/ready output register with pass-through drain; a load
// while the held entry is being consumed keeps valid high with the new entry.
module proj_kmer_out_reg #(
    parameter int DATA_BITS = 32,
    parameter int IDX_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 last_i,
    input  logic [IDX_BITS-1:0]  index_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 last_o,
    output logic [IDX_BITS-1:0]  index_o
);

    logic                 valid_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 last_q;
    logic [IDX_BITS-1:0]  index_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            index_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            index_q <= index_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign index_o = index_q;

endmodule

// File: rtl/proj_kmer_builder.sv
// Sliding-window k-mer builder: shifts in 2-bit bases and emits one packed
// k-mer per window position, restarting the window at every sequence end.
module proj_kmer_builder #(
    parameter int KMER_LEN         = proj_pkg::KMER_LEN,
    parameter int BASE_BITS        = proj_pkg::BASE_LEN,
    parameter int HASHER_DATA_BITS = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int IDX_BITS         = proj_pkg::KMER_IDX_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        base_valid,
    output logic                        base_ready,
    input  logic [BASE_BITS-1:0]        base_data,
    input  logic                        base_last,
    output logic                        kmer_valid,
    input  logic                        kmer_ready,
    output logic [HASHER_DATA_BITS-1:0] kmer_data,
    output logic                        kmer_last,
    output logic [IDX_BITS-1:0]         kmer_index,
    output logic                        short_seq
);

    import proj_pkg::*;

    localparam int WIN_BITS  = KMER_LEN * BASE_BITS;
    localparam int FILL_BITS = $clog2(KMER_LEN + 1);
    localparam logic [FILL_BITS-1:0] FILL_LAST = FILL_BITS'(KMER_LEN - 1);

    kmer_state_e          state_q, state_d;
    logic [WIN_BITS-1:0]  window_q, window_d, window_shift;
    logic [FILL_BITS-1:0] fill_q, fill_d;
    logic [IDX_BITS-1:0]  pos_q, pos_d;
    logic                 short_q, short_d;
    logic                 accept, emit;

    assign base_ready   = !rst && (!kmer_valid || kmer_ready);
    assign accept       = base_valid && base_ready;
    assign window_shift = {window_q[WIN_BITS-BASE_BITS-1:0], base_data};
    // The base that completes the first window emits in the same accept.
    assign emit         = accept && (state_q == ST_STREAM || fill_q == FILL_LAST);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        fill_d   = fill_q;
        pos_d    = pos_q;
        short_d  = 1'b0;
        if (accept) begin
            if (emit) begin
                pos_d = pos_q + IDX_BITS'(1);
            end
            if (base_last) begin
                state_d  = ST_FILL;
                window_d = '0;
                fill_d   = '0;
                pos_d    = '0;
                short_d  = !emit;
            end else begin
                window_d = window_shift;
                if (state_q == ST_FILL) begin
                    fill_d = fill_q + FILL_BITS'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_STREAM;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            window_q <= '0;
            fill_q   <= '0;
            pos_q    <= '0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            pos_q    <= pos_d;
            short_q  <= short_d;
        end
    end

    assign short_seq = short_q;

    proj_kmer_out_reg #(
        .DATA_BITS (HASHER_DATA_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (emit),
        .data_i  (HASHER_DATA_BITS'(window_shift)),
        .last_i  (base_last),
        .index_i (pos_q),
        .ready_i (kmer_ready),
        .valid_o (kmer_valid),
        .data_o  (kmer_data),
        .last_o  (kmer_last),
        .index_o (kmer_index)
    );

endmodule

// File: doc/proj_kmer_builder.md
Name: proj_kmer_builder

Overview:
Upstream neighbour of proj_hasher. It consumes a stream of 2-bit DNA bases, one per handshake, and keeps a sliding window of the last KMER_LEN bases. For every window position it emits a packed k-mer, zero-extended to HASHER_DATA_BITS, which drives proj_hasher's kmer input directly. Sequences are delimited by base_last. The window restarts empty at every sequence boundary.

Parameters:
- KMER_LEN, proj_pkg::KMER_LEN (16): bases per k-mer; must be ≥ 2.
- BASE_BITS, proj_pkg::BASE_LEN (2): bits per base; encoding A=0, C=1, G=2, T=3.
- HASHER_DATA_BITS, proj_pkg::HASHER_SORTER_SIGNATURE (32): output width; KMER_LEN*BASE_BITS ≤ HASHER_DATA_BITS.
- IDX_BITS, 16: width of the k-mer position index.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- base_valid  in  1  upstream base available
- base_ready  out  1  builder accepts a base this cycle
- base_data  in  BASE_BITS  base code
- base_last  in  1  this base is the final base of the sequence
- kmer_valid  out  1  kmer_data/kmer_last/kmer_index valid
- kmer_ready  in  1  downstream (hasher/sorter path) consumes the k-mer
- kmer_data  out  HASHER_DATA_BITS  packed k-mer: newest base in [BASE_BITS-1:0], oldest at the top of the KMER_LEN*BASE_BITS field; upper bits 0
- kmer_last  out  1  final k-mer of the sequence
- kmer_index  out  IDX_BITS  k-mer position within the sequence, first = 0
- short_seq  out  1  one-cycle pulse: sequence ended with fewer than KMER_LEN bases

Behaviour:
- Reset: all regs clear. kmer_valid=0, kmer_data=0, kmer_last=0, kmer_index=0, short_seq=0, fill=0, state=FILL. base_ready=0 while rst=1.
- base_ready = !rst && (!kmer_valid || kmer_ready). This is a single output register with pass-through drain, so full throughput is 1 base/cycle.
- Accept = base_valid && base_ready. On accept: window <= {window[(KMER_LEN-1)*BASE_BITS-1:0], base_data}.
- State FILL (fill < KMER_LEN-1):
  - Accept increments fill.
  - If the accepted base reaches KMER_LEN bases, the k-mer is emitted in the same accept (next cycle kmer_valid=1) and the state goes to STREAM.
- State STREAM: every accept emits a k-mer.
- Emit: kmer_data <= zero-extended new window; kmer_valid <= 1; kmer_last <= base_last; kmer_index <= pos; pos <= pos+1. pos wraps mod 2^IDX_BITS with no flag.
- Latency: one cycle from base accept to kmer_valid.
- Output handling:
  - kmer_valid && !kmer_ready: kmer_data, kmer_last and kmer_index hold stable; no base is accepted.
  - kmer_ready without a new emit clears kmer_valid.
  - Simultaneous drain and emit loads the new k-mer with kmer_valid staying 1.
- base_last on accept:
  - After this base's shift and emit, fill, pos and window clear and the state goes to FILL.
  - If fewer than KMER_LEN bases were seen including this one, no k-mer is emitted and short_seq=1 for exactly the next cycle.
  - A new sequence may start on the very next cycle.
- base_data is ignored when base_valid=0. X on base_data without base_valid must not propagate.
- rst mid-sequence: partial window, pending k-mer and short_seq are discarded; the next base starts a new sequence at index 0.

Decomposition:
- proj_pkg adds:
  - the typedef base_t (logic [BASE_LEN-1:0]);
  - the constants BASE_A/C/G/T;
  - KMER_BITS = KMER_LEN*BASE_LEN;
  - KMER_IDX_BITS = 16.
- proj_pkg keeps its existing KMER_LEN, BASE_LEN and HASHER_SORTER_SIGNATURE.
- Optional sub-module proj_kmer_out_reg holds the single-entry valid/ready output register, reusable in front of the sorter.
- Top-level integration: kmer_data wires straight to proj_hasher.kmer.

Test Plan (KMER_LEN=4, BASE_BITS=2, HASHER_DATA_BITS=32 unless noted):
- Sequence A,C,G,T,A with A last, kmer_ready=1, back-to-back -> two k-mers:
  - 0x0000001B, index 0, last=0, one cycle after the 4th accept;
  - 0x0000006C, index 1, last=1.
- Same stream with kmer_ready held 0 for 5 cycles after the first k-mer -> base_ready=0, kmer_data stays 0x1B, no base is lost; releasing gives 0x6C next.
- Sequence G,G,T with T last -> no kmer_valid, short_seq=1 for one cycle. Following sequence T,T,T,T (last on the 4th base) -> 0x000000FF, index 0, last=1.
- rst asserted after 3 bases of a sequence, then A,A,A,C -> first k-mer 0x00000001, index 0; no residue from before reset.
- Default parameters (KMER_LEN=16), 20 random bases then last -> 5 k-mers, indices 0..4, each equal to the reference sliding-window model; the k-mers feed proj_hasher with seed 0xac718add and the signatures are compared against the hasher model.
- Random base_valid/kmer_ready toggling over 1000 bases across 10 sequences -> the scoreboard matches the model order with no drops or duplicates, and kmer_last appears exactly once per sequence of ≥ KMER_LEN bases.
